arbitro_memoria_dados: RTL

Two-port arbiter in front of the data memory (sync write, 1-cycle sync read, 2-bit DataType). Shares it between port 0 (processor load/store/stack path) and port 1 (I/O / program-loader master). Registers the winning command, drives the memory strobes for one access cycle, then returns read data with a valid pulse. Round-robin by default, so the loader cannot starve the processor or vice versa.

---
 rtl/arbitro_memoria_dados_if.sv | 48 ++++
 rtl/arbitro_memoria_dados.sv | 135 +++++++++++++
 2 files changed

// File: rtl/arbitro_memoria_dados_if.sv
// Bus bundle for arbitro_memoria_dados: two requester ports, shared read data and the memory side.
// slave = arbiter view, master = requesters plus memory (environment) view.
interface arbitro_memoria_dados_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  // Port 0: processor load/store/stack path
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic [1:0]        dtype0;
  logic              gnt0;
  logic              rvalid0;
  // Port 1: I/O / program-loader master
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        dtype1;
  logic              gnt1;
  logic              rvalid1;
  // Shared read data and memory side
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [1:0]        mem_dtype;
  logic              mem_escmen;
  logic              mem_lermen;
  logic [DATA_W-1:0] mem_saida;
  logic              ocupado;

  modport slave (
    input  req0, we0, addr0, wdata0, dtype0,
    input  req1, we1, addr1, wdata1, dtype1,
    input  mem_saida,
    output gnt0, rvalid0, gnt1, rvalid1, rdata,
    output mem_addr, mem_data, mem_dtype, mem_escmen, mem_lermen, ocupado
  );

  modport master (
    output req0, we0, addr0, wdata0, dtype0,
    output req1, we1, addr1, wdata1, dtype1,
    output mem_saida,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata,
    input  mem_addr, mem_data, mem_dtype, mem_escmen, mem_lermen, ocupado
  );
endinterface

// File: rtl/arbitro_memoria_dados.sv
// Two-port data-memory arbiter: registers the winning command, strobes memory for one cycle, returns read data.
// Round-robin by default; define PRIORIDADE_PROCESSADOR_EN for fixed priority to port 0.
module arbitro_memoria_dados #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  arbitro_memoria_dados_if.slave  bus
);

  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] ACESSO   = 2'd1;
  localparam logic [1:0] RESPOSTA = 2'd2;

  logic [1:0]        state_q,     state_d;
  logic              porta_q,     porta_d;
  logic              gnt0_q,      gnt0_d;
  logic              gnt1_q,      gnt1_d;
  logic              rvalid0_q,   rvalid0_d;
  logic              rvalid1_q,   rvalid1_d;
  logic [DATA_W-1:0] rdata_q,     rdata_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_data_q,  mem_data_d;
  logic [1:0]        mem_dtype_q, mem_dtype_d;
  logic              escmen_q,    escmen_d;
  logic              lermen_q,    lermen_d;
  logic              ocupado_q,   ocupado_d;
  logic              vence1_c;

`ifdef PRIORIDADE_PROCESSADOR_EN
  // Port 1 only wins when port 0 is silent
  assign vence1_c = bus.req1 & ~bus.req0;
`else
  logic ultimo_q, ultimo_d;
  // On a tie the port that did not win last time is served
  assign vence1_c = bus.req1 & (~bus.req0 | ~ultimo_q);
`endif

  always_comb begin
    state_d     = state_q;
    porta_d     = porta_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_dtype_d = mem_dtype_q;
    escmen_d    = 1'b0;
    lermen_d    = 1'b0;
`ifndef PRIORIDADE_PROCESSADOR_EN
    ultimo_d    = ultimo_q;
`endif
    case (state_q)
      OCIOSO: begin
        if (bus.req0 | bus.req1) begin
          porta_d     = vence1_c;
          gnt0_d      = ~vence1_c;
          gnt1_d      = vence1_c;
          mem_addr_d  = vence1_c ? bus.addr1  : bus.addr0;
          mem_data_d  = vence1_c ? bus.wdata1 : bus.wdata0;
          mem_dtype_d = vence1_c ? bus.dtype1 : bus.dtype0;
          escmen_d    = vence1_c ? bus.we1    : bus.we0;
          lermen_d    = ~(vence1_c ? bus.we1  : bus.we0);
          state_d     = ACESSO;
`ifndef PRIORIDADE_PROCESSADOR_EN
          ultimo_d    = vence1_c;
`endif
        end
      end
      ACESSO:   state_d = escmen_q ? OCIOSO : RESPOSTA;
      RESPOSTA: begin
        rdata_d   = bus.mem_saida;
        rvalid0_d = ~porta_q;
        rvalid1_d = porta_q;
        state_d   = OCIOSO;
      end
      default:  state_d = OCIOSO;
    endcase
    ocupado_d = (state_d != OCIOSO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= OCIOSO;
      porta_q     <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_dtype_q <= 2'd0;
      escmen_q    <= 1'b0;
      lermen_q    <= 1'b0;
      ocupado_q   <= 1'b0;
`ifndef PRIORIDADE_PROCESSADOR_EN
      ultimo_q    <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      porta_q     <= porta_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_dtype_q <= mem_dtype_d;
      escmen_q    <= escmen_d;
      lermen_q    <= lermen_d;
      ocupado_q   <= ocupado_d;
`ifndef PRIORIDADE_PROCESSADOR_EN
      ultimo_q    <= ultimo_d;
`endif
    end
  end

  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.rvalid0    = rvalid0_q;
  assign bus.rvalid1    = rvalid1_q;
  assign bus.rdata      = rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_data   = mem_data_q;
  assign bus.mem_dtype  = mem_dtype_q;
  assign bus.mem_escmen = escmen_q;
  assign bus.mem_lermen = lermen_q;
  assign bus.ocupado    = ocupado_q;

endmodule
